// File: rtl/cache_miss_handler_wb.sv
// Set-associative L1 miss handler: writes back a dirty victim, fetches the missing line
// beat by beat, merges write-miss data, then issues a single-cycle fill to the LRU way.
module cache_miss_handler_wb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned WORDS   = 4,
    parameter int unsigned WAYS    = 4,
    parameter int unsigned INDEX_W = 8,
    localparam int unsigned BEAT_W = $clog2(WORDS),
    localparam int unsigned BYTE_W = $clog2(DATA_W / 8),
    localparam int unsigned OFF_W  = BEAT_W + BYTE_W,
    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFF_W,
    localparam int unsigned WAY_W  = $clog2(WAYS),
    localparam int unsigned LINE_W = WORDS * DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                miss_vld,
    output logic                miss_rdy,
    input  logic                miss_is_wr,
    input  logic [ADDR_W-1:0]   miss_addr,
    input  logic [DATA_W-1:0]   miss_wr_data,
    input  logic [WAY_W-1:0]    lru_way,
    input  logic                victim_dirty,
    input  logic [TAG_W-1:0]    victim_tag,
    input  logic [LINE_W-1:0]   victim_data,
    output logic                l2_rd_req,
    input  logic                l2_rd_gnt,
    output logic [ADDR_W-1:0]   l2_rd_addr,
    input  logic [DATA_W-1:0]   l2_rd_data,
    output logic                l2_wr_req,
    input  logic                l2_wr_gnt,
    output logic [ADDR_W-1:0]   l2_wr_addr,
    output logic [DATA_W-1:0]   l2_wr_data,
    output logic                fill_vld,
    output logic [WAY_W-1:0]    fill_way,
    output logic [INDEX_W-1:0]  fill_index,
    output logic [TAG_W-1:0]    fill_tag,
    output logic [LINE_W-1:0]   fill_data,
    output logic                fill_dirty
);

    typedef enum logic [1:0] {StIdle, StEvict, StFetch, StFill} state_e;

    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(WORDS - 1);
    localparam logic [BEAT_W-1:0] OneBeat  = BEAT_W'(1);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                is_wr_q, is_wr_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [BEAT_W-1:0]   woff_q, woff_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [TAG_W-1:0]    vtag_q, vtag_d;
    logic [LINE_W-1:0]   vdata_q, vdata_d;
    logic [LINE_W-1:0]   line_q, line_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            is_wr_q   <= 1'b0;
            tag_q     <= '0;
            index_q   <= '0;
            woff_q    <= '0;
            wr_data_q <= '0;
            way_q     <= '0;
            vtag_q    <= '0;
            vdata_q   <= '0;
            line_q    <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            is_wr_q   <= is_wr_d;
            tag_q     <= tag_d;
            index_q   <= index_d;
            woff_q    <= woff_d;
            wr_data_q <= wr_data_d;
            way_q     <= way_d;
            vtag_q    <= vtag_d;
            vdata_q   <= vdata_d;
            line_q    <= line_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        is_wr_d   = is_wr_q;
        tag_d     = tag_q;
        index_d   = index_q;
        woff_d    = woff_q;
        wr_data_d = wr_data_q;
        way_d     = way_q;
        vtag_d    = vtag_q;
        vdata_d   = vdata_q;
        line_d    = line_q;
        unique case (state_q)
            StIdle: begin
                if (miss_vld) begin
                    is_wr_d   = miss_is_wr;
                    tag_d     = miss_addr[ADDR_W-1 -: TAG_W];
                    index_d   = miss_addr[OFF_W +: INDEX_W];
                    woff_d    = miss_addr[BYTE_W +: BEAT_W];
                    wr_data_d = miss_wr_data;
                    way_d     = lru_way;
                    beat_d    = '0;
                    if (victim_dirty) begin
                        vtag_d  = victim_tag;
                        vdata_d = victim_data;
                        state_d = StEvict;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StEvict: begin
                if (l2_wr_gnt) begin
                    beat_d = beat_q + OneBeat;
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (l2_rd_gnt) begin
                    // Store data for a write miss overrides the L2 word it targets.
                    if (is_wr_q && (beat_q == woff_q)) begin
                        line_d[beat_q*DATA_W +: DATA_W] = wr_data_q;
                    end else begin
                        line_d[beat_q*DATA_W +: DATA_W] = l2_rd_data;
                    end
                    beat_d = beat_q + OneBeat;
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                beat_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign miss_rdy   = (state_q == StIdle);
    assign l2_wr_req  = (state_q == StEvict);
    assign l2_rd_req  = (state_q == StFetch);
    assign fill_vld   = (state_q == StFill);

    assign l2_wr_addr = l2_wr_req ? {vtag_q, index_q, beat_q, {BYTE_W{1'b0}}} : '0;
    assign l2_wr_data = l2_wr_req ? vdata_q[beat_q*DATA_W +: DATA_W] : '0;
    assign l2_rd_addr = l2_rd_req ? {tag_q, index_q, beat_q, {BYTE_W{1'b0}}} : '0;

    assign fill_way   = way_q;
    assign fill_index = index_q;
    assign fill_tag   = tag_q;
    assign fill_data  = line_q;
    assign fill_dirty = is_wr_q;

endmodule
